// File: rtl/sha_arbiter.sv
// Round-robin owner arbitration and sequencing for the shared SHA-256 engine, with watchdog revoke.
// Grant is registered one cycle after a sampled request; the owner's SHA controls pass through combinationally.
// Handover waits in DRAIN until the engine signals sha_ready; non-owners wait with their req held.
module sha_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int BLOCK_W     = 512,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            rel,
    input  logic [NUM_REQ*BLOCK_W-1:0]    req_sha_block,
    input  logic [NUM_REQ-1:0]            req_sha_init,
    input  logic [NUM_REQ-1:0]            req_sha_next,
    input  logic [NUM_REQ-1:0]            req_sha_sel,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    output logic                          busy,
    output logic [BLOCK_W-1:0]            sha_block,
    output logic                          sha_init,
    output logic                          sha_next,
    output logic                          sha_sel,
    input  logic                          sha_ready,
    input  logic                          sha_digest_valid,
    output logic                          wdog_irq,
    output logic [NUM_REQ-1:0]            wdog_status,
    input  logic [NUM_REQ-1:0]            wdog_clr
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(WDOG_CYCLES) + 1;
    localparam logic [CW-1:0] WD_TERM = CW'(WDOG_CYCLES - 1);
    localparam logic [CW-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  wdog_status_q, wdog_status_d, wdog_set;
    logic [IDW-1:0]      gnt_id_q, gnt_id_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      win_id;
    logic                win_vld;
    logic                wdog_irq_q, wdog_irq_d;
    logic                boot_wait_q, boot_wait_d;
    logic [CW-1:0]       wdog_cnt_q, wdog_cnt_d;
    logic                owned, own_req, own_init, own_next, own_rel, own_activity;
    int                  cand;

    assign owned        = (state_q == OWNED);
    assign own_req      = req[gnt_id_q];
    assign own_init     = req_sha_init[gnt_id_q];
    assign own_next     = req_sha_next[gnt_id_q];
    // Only a lone release bit from the owner counts; anything else is treated as noise.
    assign own_rel      = (rel == gnt_q);
    assign own_activity = own_init | own_next | sha_digest_valid;

    // Walk downwards so the candidate nearest to rr_ptr+1 is assigned last and wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (req[cand]) begin
                win_vld = 1'b1;
                win_id  = IDW'(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        rr_ptr_d    = rr_ptr_q;
        wdog_cnt_d  = wdog_cnt_q;
        wdog_irq_d  = 1'b0;
        wdog_set    = '0;
        boot_wait_d = boot_wait_q;

        case (state_q)
            IDLE: begin
                if (sha_ready) begin
                    boot_wait_d = 1'b0;
                end
                // After reset the engine may still be mid-hash, so the first grant waits for ready.
                if (win_vld && (!boot_wait_q || sha_ready)) begin
                    state_d         = OWNED;
                    gnt_d           = '0;
                    gnt_d[win_id]   = 1'b1;
                    gnt_id_d        = win_id;
                    rr_ptr_d        = win_id;
                    wdog_cnt_d      = '0;
                end
            end
            OWNED: begin
                if (own_rel || !own_req) begin
                    state_d    = DRAIN;
                    gnt_d      = '0;
                    wdog_cnt_d = '0;
                end else if (!own_activity && (wdog_cnt_q >= WD_TERM)) begin
                    state_d    = DRAIN;
                    gnt_d      = '0;
                    wdog_cnt_d = '0;
                    wdog_irq_d = 1'b1;
                    wdog_set   = gnt_q;
                end else if (own_activity) begin
                    wdog_cnt_d = '0;
                end else if (wdog_cnt_q != WD_MAX) begin
                    wdog_cnt_d = wdog_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (sha_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // A set on the same cycle as a clear leaves the bit set.
    assign wdog_status_d = (wdog_status_q & ~wdog_clr) | wdog_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            gnt_id_q      <= '0;
            rr_ptr_q      <= IDW'(NUM_REQ - 1);
            wdog_cnt_q    <= '0;
            wdog_irq_q    <= 1'b0;
            wdog_status_q <= '0;
            boot_wait_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_id_q      <= gnt_id_d;
            rr_ptr_q      <= rr_ptr_d;
            wdog_cnt_q    <= wdog_cnt_d;
            wdog_irq_q    <= wdog_irq_d;
            wdog_status_q <= wdog_status_d;
            boot_wait_q   <= boot_wait_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign busy        = owned;
    assign wdog_irq    = wdog_irq_q;
    assign wdog_status = wdog_status_q;

    assign sha_block = owned ? req_sha_block[int'(gnt_id_q)*BLOCK_W +: BLOCK_W] : '0;
    assign sha_init  = owned & own_init;
    assign sha_next  = owned & own_next;
    assign sha_sel   = owned & req_sha_sel[gnt_id_q];

endmodule

// File: tb/tb_sha_arbiter.sv
// Bench for sha_arbiter: per-cycle vector table with a queue of expected registered outputs,
// followed by fairness, watchdog, collision and reset-mid-hash sequences.
module tb_sha_arbiter;
    localparam int NR = 2;
    localparam int BW = 512;
    localparam int WD = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req, rel, req_sha_init, req_sha_next, req_sha_sel, wdog_clr;
    logic [NR*BW-1:0]  req_sha_block;
    logic [NR-1:0]     gnt, wdog_status;
    logic [0:0]        gnt_id;
    logic              busy, sha_init, sha_next, sha_sel, sha_ready, sha_digest_valid, wdog_irq;
    logic [BW-1:0]     sha_block;

    logic [BW-1:0]     blk0, blk1;
    int                checks = 0;
    int                errors = 0;

    typedef struct {
        logic [1:0] req, rel, ini, nxt;
        logic       rdy;
        logic [1:0] src;
        logic       e_ini, e_nxt;
        logic [1:0] e_gnt;
        logic       e_busy;
        logic       e_id;
    } vec_t;

    typedef struct {
        logic [1:0] gnt;
        logic       busy;
        logic       id;
        logic       irq;
    } exp_t;

    vec_t        tv[18];
    exp_t        sb[$];
    logic [1:0]  gq[$];

    sha_arbiter #(.NUM_REQ(NR), .BLOCK_W(BW), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
        .req_sha_block(req_sha_block), .req_sha_init(req_sha_init),
        .req_sha_next(req_sha_next), .req_sha_sel(req_sha_sel),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .sha_block(sha_block),
        .sha_init(sha_init), .sha_next(sha_next), .sha_sel(sha_sel),
        .sha_ready(sha_ready), .sha_digest_valid(sha_digest_valid),
        .wdog_irq(wdog_irq), .wdog_status(wdog_status), .wdog_clr(wdog_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; rel = '0; req_sha_init = '0; req_sha_next = '0; wdog_clr = '0;
        sha_ready = 1'b1; sha_digest_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [BW-1:0] src_blk(input logic [1:0] src);
        return (src == 2'd1) ? blk0 : (src == 2'd2) ? blk1 : '0;
    endfunction

    initial begin
        exp_t        e;
        logic [1:0]  eg;
        logic        seen;
        blk0 = {32'h61626380, 416'h0, 64'h18};
        blk1 = '1;
        req_sha_block = {blk1, blk0};
        req_sha_sel   = 2'b01;

        //          req    rel    ini    nxt    rdy  src  eIni eNxt eGnt   eBusy eId
        tv[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tv[1]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        tv[2]  = '{2'b01, 2'b00, 2'b01, 2'b00, 1'b1, 2'd1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
        tv[3]  = '{2'b11, 2'b00, 2'b10, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        tv[4]  = '{2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 2'd1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0};
        tv[5]  = '{2'b11, 2'b10, 2'b00, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        tv[6]  = '{2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        tv[7]  = '{2'b11, 2'b01, 2'b01, 2'b00, 1'b1, 2'd1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        tv[8]  = '{2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tv[9]  = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tv[10] = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1};
        tv[11] = '{2'b11, 2'b00, 2'b10, 2'b00, 1'b1, 2'd2, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1};
        tv[12] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tv[13] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tv[14] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        tv[15] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tv[16] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tv[17] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

        // Reset values while held in reset.
        rst_n = 1'b0;
        req = '0; rel = '0; req_sha_init = '0; req_sha_next = '0; wdog_clr = '0;
        sha_ready = 1'b1; sha_digest_valid = 1'b0;
        #12;
        chk("reset_outs", BW'({gnt, busy, gnt_id, wdog_irq, wdog_status, sha_init, sha_next, sha_sel}), '0);
        chk("reset_blk", sha_block, '0);
        do_reset();

        // Vector table: comb outputs checked before the edge, registered ones via the queue after it.
        for (int i = 0; i < 18; i++) begin
            req = tv[i].req; rel = tv[i].rel; req_sha_init = tv[i].ini;
            req_sha_next = tv[i].nxt; sha_ready = tv[i].rdy;
            #1;
            chk($sformatf("v%0d_blk", i), sha_block, src_blk(tv[i].src));
            chk($sformatf("v%0d_ctl", i), BW'({sha_init, sha_next, sha_sel}),
                BW'({tv[i].e_ini, tv[i].e_nxt, tv[i].src == 2'd1}));
            sb.push_back('{tv[i].e_gnt, tv[i].e_busy, tv[i].e_id, 1'b0});
            tick();
            e = sb.pop_front();
            chk($sformatf("v%0d_gnt", i), BW'(gnt), BW'(e.gnt));
            chk($sformatf("v%0d_busy", i), BW'(busy), BW'(e.busy));
            chk($sformatf("v%0d_irq", i), BW'(wdog_irq), BW'(e.irq));
            if (e.busy) chk($sformatf("v%0d_id", i), BW'(gnt_id), BW'(e.id));
        end

        // Fairness: both requesting, each owner releases after holding 5 cycles.
        do_reset();
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10);
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            int waited = 0;
            while (!busy && waited < 10) begin
                tick();
                waited++;
            end
            if (!busy) begin
                checks++; errors++;
                $display("FAIL fair_timeout grant %0d actual=none required=%0b", g, gq[0]);
                break;
            end
            eg = gq.pop_front();
            chk($sformatf("fair_gnt%0d", g), BW'(gnt), BW'(eg));
            repeat (4) tick();
            rel = gnt;
            tick();
            rel = '0;
        end
        req = '0;

        // Watchdog revoke of a silent owner.
        do_reset();
        req = 2'b10;
        tick();
        chk("wd_gnt", BW'(gnt), BW'(2'b10));
        seen = 1'b0;
        for (int k = 1; k <= WD - 1; k++) begin
            tick();
            if (wdog_irq) seen = 1'b1;
        end
        chk("wd_no_early_irq", BW'(seen), '0);
        chk("wd_still_owned", BW'(gnt), BW'(2'b10));
        tick();
        chk("wd_irq", BW'(wdog_irq), BW'(1'b1));
        chk("wd_status", BW'(wdog_status), BW'(2'b10));
        chk("wd_revoked", BW'({gnt, busy}), '0);
        req = '0;
        tick();
        chk("wd_irq_pulse", BW'(wdog_irq), '0);
        chk("wd_sticky", BW'(wdog_status), BW'(2'b10));
        wdog_clr = 2'b10;
        tick();
        wdog_clr = '0;
        chk("wd_clr", BW'(wdog_status), '0);

        // Release on the terminal-count cycle beats the watchdog.
        do_reset();
        req = 2'b01;
        tick();
        chk("col_gnt", BW'(gnt), BW'(2'b01));
        repeat (WD - 1) tick();
        rel = 2'b01;
        tick();
        rel = '0;
        chk("col_no_irq", BW'(wdog_irq), '0);
        chk("col_status", BW'(wdog_status), '0);
        chk("col_released", BW'({gnt, busy}), '0);
        tick();
        chk("col_no_late_irq", BW'(wdog_irq), '0);

        // Reset mid-hash, then the first grant waits for sha_ready.
        do_reset();
        req = 2'b01;
        tick();
        req_sha_init = 2'b01;
        #1;
        chk("rst_pre_init", BW'(sha_init), BW'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", BW'({gnt, busy, sha_init, sha_sel}), '0);
        chk("rst_async_blk", sha_block, '0);
        req_sha_init = '0;
        sha_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (gnt != 2'b00) seen = 1'b1;
        end
        chk("rst_wait_ready", BW'(seen), '0);
        sha_ready = 1'b1;
        tick();
        chk("rst_gnt_after_ready", BW'(gnt), BW'(2'b01));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
